// File: rtl/md_unit_if.sv
// E-stage multiply/divide command and result bundle.
interface md_unit_if;
   logic [3:0]  md_op;
   logic        flush;
   logic [31:0] A;
   logic [31:0] B;
   logic        rd_sel;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] md_out;

   modport master (
      output md_op, flush, A, B, rd_sel,
      input  busy, hi, lo, md_out
   );

   modport slave (
      input  md_op, flush, A, B, rd_sel,
      output busy, hi, lo, md_out
   );
endinterface

// File: rtl/md_unit.sv
// MIPS E-stage multiply/divide unit with HI/LO and a busy-cycle counter FSM.
// Optional madd/maddu/msub/msubu support under `define MDU_MADD_EN.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic   clk,
   input logic   rst_n,
   md_unit_if.slave md
);

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   typedef enum logic {IDLE, RUN} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        commit_q, commit_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;

   logic is_mul, is_mulu, is_div, is_divu;
   logic is_mthi, is_mtlo;

   assign is_mul  = md.md_op == 4'd1;
   assign is_mulu = md.md_op == 4'd2;
   assign is_div  = md.md_op == 4'd3;
   assign is_divu = md.md_op == 4'd4;
   assign is_mthi = md.md_op == 4'd5;
   assign is_mtlo = md.md_op == 4'd6;

   logic signed [63:0] a_s, b_s;
   logic [63:0] prod_s, prod_u;
   logic [31:0] dvsr;
   logic [31:0] q_s, r_s, q_u, r_u;

   assign a_s    = {{32{md.A[31]}}, md.A};
   assign b_s    = {{32{md.B[31]}}, md.B};
   assign prod_s = a_s * b_s;
   assign prod_u = {32'b0, md.A} * {32'b0, md.B};
   // Divisor forced nonzero; a zero divide never commits anyway.
   assign dvsr   = (md.B == 32'b0) ? 32'd1 : md.B;
   assign q_s    = $signed(md.A) / $signed(dvsr);
   assign r_s    = $signed(md.A) % $signed(dvsr);
   assign q_u    = md.A / dvsr;
   assign r_u    = md.A % dvsr;

`ifdef MDU_MADD_EN
   logic is_madd, is_maddu, is_msub, is_msubu;
   logic [63:0] acc;

   assign is_madd  = md.md_op == 4'd7;
   assign is_maddu = md.md_op == 4'd8;
   assign is_msub  = md.md_op == 4'd9;
   assign is_msubu = md.md_op == 4'd10;
   assign acc      = {hi_q, lo_q};
`endif

   logic        start;
   logic [63:0] start_val;
   logic [3:0]  start_n;
   logic        start_commit;

   always_comb begin
      start        = 1'b0;
      start_val    = 64'b0;
      start_n      = MULT_N;
      start_commit = 1'b1;
      state_d      = state_q;
      cnt_d        = cnt_q;
      busy_d       = busy_q;
      commit_d     = commit_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      pend_hi_d    = pend_hi_q;
      pend_lo_d    = pend_lo_q;
      unique case (state_q)
         IDLE: begin
            if (!md.flush) begin
               unique case (1'b1)
                  is_mul: begin
                     start     = 1'b1;
                     start_val = prod_s;
                  end
                  is_mulu: begin
                     start     = 1'b1;
                     start_val = prod_u;
                  end
                  is_div: begin
                     start        = 1'b1;
                     start_val    = {r_s, q_s};
                     start_n      = DIV_N;
                     start_commit = md.B != 32'b0;
                  end
                  is_divu: begin
                     start        = 1'b1;
                     start_val    = {r_u, q_u};
                     start_n      = DIV_N;
                     start_commit = md.B != 32'b0;
                  end
                  is_mthi: hi_d = md.A;
                  is_mtlo: lo_d = md.A;
`ifdef MDU_MADD_EN
                  is_madd: begin
                     start     = 1'b1;
                     start_val = acc + prod_s;
                  end
                  is_maddu: begin
                     start     = 1'b1;
                     start_val = acc + prod_u;
                  end
                  is_msub: begin
                     start     = 1'b1;
                     start_val = acc - prod_s;
                  end
                  is_msubu: begin
                     start     = 1'b1;
                     start_val = acc - prod_u;
                  end
`endif
                  default: ;
               endcase
            end
            if (start) begin
               state_d   = RUN;
               busy_d    = 1'b1;
               cnt_d     = start_n;
               commit_d  = start_commit;
               pend_hi_d = start_val[63:32];
               pend_lo_d = start_val[31:0];
            end
         end
         RUN: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               if (commit_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 4'b0;
         busy_q    <= 1'b0;
         commit_q  <= 1'b0;
         hi_q      <= 32'b0;
         lo_q      <= 32'b0;
         pend_hi_q <= 32'b0;
         pend_lo_q <= 32'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         commit_q  <= commit_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
      end
   end

   assign md.busy   = busy_q;
   assign md.hi     = hi_q;
   assign md.lo     = lo_q;
   assign md.md_out = md.rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against a cycle-count model.
// Directed cases pin the model with hand-computed HI/LO values.
module tb_md_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   md_unit_if bus ();

   md_unit #(
      .MULT_CYCLES(MC),
      .DIV_CYCLES (DC)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .md   (bus)
   );

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   int          m_rem;
   bit          m_pc;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_hi  = '0;
      m_lo  = '0;
      m_phi = '0;
      m_plo = '0;
      m_rem = 0;
      m_pc  = 1'b0;
   endtask

   task automatic sched(input logic [63:0] v, input int n, input bit c);
      m_phi = v[63:32];
      m_plo = v[31:0];
      m_rem = n;
      m_pc  = c;
   endtask

   // One clock edge of architectural behaviour: remaining-cycle countdown.
   task automatic model_step();
      logic [63:0] ps, pu;
      int sa, sb;
      int unsigned ua, ub;
      ps = 64'(longint'($signed(bus.A)) * longint'($signed(bus.B)));
      pu = {32'b0, bus.A} * {32'b0, bus.B};
      sa = $signed(bus.A);
      sb = $signed(bus.B);
      ua = bus.A;
      ub = bus.B;
      if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0 && m_pc) begin
            m_hi = m_phi;
            m_lo = m_plo;
         end
      end else if (!bus.flush) begin
         case (bus.md_op)
            4'd1: sched(ps, MC, 1'b1);
            4'd2: sched(pu, MC, 1'b1);
            4'd3: begin
               if (sb == 0) sched(64'b0, DC, 1'b0);
               else sched({32'(sa % sb), 32'(sa / sb)}, DC, 1'b1);
            end
            4'd4: begin
               if (ub == 0) sched(64'b0, DC, 1'b0);
               else sched({32'(ua % ub), 32'(ua / ub)}, DC, 1'b1);
            end
            4'd5: m_hi = bus.A;
            4'd6: m_lo = bus.A;
`ifdef MDU_MADD_EN
            4'd7:  sched({m_hi, m_lo} + ps, MC, 1'b1);
            4'd8:  sched({m_hi, m_lo} + pu, MC, 1'b1);
            4'd9:  sched({m_hi, m_lo} - ps, MC, 1'b1);
            4'd10: sched({m_hi, m_lo} - pu, MC, 1'b1);
`endif
            default: ;
         endcase
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", {31'b0, bus.busy}, {31'b0, m_rem > 0});
         chk("hi", bus.hi, m_hi);
         chk("lo", bus.lo, m_lo);
         chk("md_out", bus.md_out, bus.rd_sel ? m_hi : m_lo);
      end
   end

   task automatic cyc(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input bit fl = 1'b0,
                      input bit rs = 1'b0);
      bus.md_op  = op;
      bus.A      = a;
      bus.B      = b;
      bus.flush  = fl;
      bus.rd_sel = rs;
      @(posedge clk);
      if (rst_n) model_step();
      #2;
   endtask

   task automatic drain(output int n);
      n = 0;
      while (bus.busy && n < 40) begin
         n++;
         cyc(4'd0, 32'd0, 32'd0);
      end
   endtask

   int n;
   logic [3:0]  r_op;
   logic [31:0] r_a, r_b;

   initial begin
      rst_n      = 1'b0;
      bus.md_op  = '0;
      bus.A      = '0;
      bus.B      = '0;
      bus.flush  = 1'b0;
      bus.rd_sel = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      rst_n  = 1'b1;
      chk_en = 1'b1;
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_hi", bus.hi, 32'd0);
      chk("rst_lo", bus.lo, 32'd0);

      cyc(4'd1, 32'hFFFF_FFFD, 32'd5);
      chk("mult_hold_hi", bus.hi, 32'd0);
      drain(n);
      chk("mult_cycles", n, 32'd5);
      chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
      chk("mult_lo", bus.lo, 32'hFFFF_FFF1);

      cyc(4'd2, 32'hFFFF_FFFF, 32'd2);
      drain(n);
      chk("multu_cycles", n, 32'd5);
      chk("multu_hi", bus.hi, 32'h0000_0001);
      chk("multu_lo", bus.lo, 32'hFFFF_FFFE);

      cyc(4'd3, 32'hFFFF_FFF9, 32'd2);
      drain(n);
      chk("div_cycles", n, 32'd10);
      chk("div_lo", bus.lo, 32'hFFFF_FFFD);
      chk("div_hi", bus.hi, 32'hFFFF_FFFF);
      cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      chk("mdout_hi", bus.md_out, 32'hFFFF_FFFF);
      cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("mdout_lo", bus.md_out, 32'hFFFF_FFFD);

      cyc(4'd5, 32'h1234, 32'd0);
      chk("mthi_hi", bus.hi, 32'h1234);
      cyc(4'd4, 32'd7, 32'd0);
      drain(n);
      chk("divz_cycles", n, 32'd10);
      chk("divz_hi", bus.hi, 32'h1234);
      chk("divz_lo", bus.lo, 32'hFFFF_FFFD);

      cyc(4'd1, 32'd3, 32'd3, 1'b1);
      chk("flush_busy", {31'b0, bus.busy}, 32'd0);
      chk("flush_lo", bus.lo, 32'hFFFF_FFFD);

      cyc(4'd1, 32'd3, 32'd3);
      cyc(4'd0, 32'd0, 32'd0);
      cyc(4'd0, 32'd0, 32'd0, 1'b1);
      drain(n);
      chk("midflush_rest", n, 32'd3);
      chk("midflush_hi", bus.hi, 32'd0);
      chk("midflush_lo", bus.lo, 32'd9);

      cyc(4'd3, 32'd100, 32'd7);
      cyc(4'd0, 32'd0, 32'd0);
      cyc(4'd0, 32'd0, 32'd0);
      cyc(4'd1, 32'd5, 32'd5);
      cyc(4'd0, 32'd0, 32'd0);
      cyc(4'd0, 32'd0, 32'd0);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_busy", {31'b0, bus.busy}, 32'd0);
      chk("arst_hi", bus.hi, 32'd0);
      chk("arst_lo", bus.lo, 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (15) cyc(4'd0, 32'd0, 32'd0);
      chk("arst_nocommit_hi", bus.hi, 32'd0);
      chk("arst_nocommit_lo", bus.lo, 32'd0);

`ifdef MDU_MADD_EN
      cyc(4'd6, 32'd5, 32'd0);
      cyc(4'd5, 32'd0, 32'd0);
      cyc(4'd7, 32'd2, 32'd3);
      drain(n);
      chk("madd_cycles", n, 32'd5);
      chk("madd_hi", bus.hi, 32'd0);
      chk("madd_lo", bus.lo, 32'hB);
      cyc(4'd10, 32'd1, 32'hC);
      drain(n);
      chk("msubu_hi", bus.hi, 32'hFFFF_FFFF);
      chk("msubu_lo", bus.lo, 32'hFFFF_FFFF);
`else
      cyc(4'd7, 32'd2, 32'd3);
      chk("op7_busy", {31'b0, bus.busy}, 32'd0);
      chk("op7_lo", bus.lo, 32'd0);
`endif

      for (int i = 0; i < 600; i++) begin
         r_op = 4'($urandom_range(0, 15));
         r_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20))
                                            : $urandom;
         case ($urandom_range(0, 7))
            0: r_b = 32'd0;
            1: r_b = 32'($urandom_range(1, 9));
            2: r_b = 32'hFFFF_FFFF;
            default: r_b = $urandom;
         endcase
         if (r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) r_b = 32'd1;
         cyc(r_op, r_a, r_b, $urandom_range(0, 9) == 0,
             1'($urandom_range(0, 1)));
      end
      drain(n);
      chk("final_idle", {31'b0, bus.busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Multiply/divide unit with its controller for the 5-stage MIPS pipeline. Sits in the E stage. It accepts mult/div/mthi/mtlo commands, sequences the multi-cycle latency with a counter FSM, and holds the architectural HI/LO registers. It exports `busy` to the stall unit, which holds D-stage md instructions while `busy` is high or an md start sits in E.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- md_op  in  4  command: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11-15 none.
- flush  in  1  exception/interrupt taken this cycle; suppresses the current command.
- A  in  32  rs operand (E-stage forwarded value).
- B  in  32  rt operand (E-stage forwarded value).
- rd_sel  in  1  mf read select: 0 LO, 1 HI.
- busy  out  1  operation in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.
- md_out  out  32  combinational: rd_sel ? hi : lo.

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, busy=0, hi=0, lo=0, internal result registers 0. Takes effect immediately. Aborts any in-flight operation; no commit.
- FSM states: IDLE and RUN.
- Command acceptance:
  - A command is accepted on a rising edge only when state=IDLE, flush=0, and md_op is a valid code.
  - Commands presented while in RUN are ignored (the stall unit prevents this).
- Accepting mult/multu/div/divu (and the madd family when enabled):
  - Result is computed from A/B at the accepting edge and held in internal pend_hi/pend_lo.
  - Counter loads N (MULT_CYCLES or DIV_CYCLES); state moves to RUN.
- RUN:
  - busy=1 and counter decrements each edge.
  - On the edge where counter==1: hi<=pend_hi, lo<=pend_lo, state moves to IDLE, busy=0 next cycle.
  - Net effect: start in cycle 0, busy high in cycles 1..N, new HI/LO visible from cycle N+1.
- flush has no effect on an operation already in RUN. It completes and commits, matching MIPS semantics.
- Arithmetic:
  - mult: {hi,lo} = signed(A) * signed(B), 64-bit.
  - multu: same as mult with both operands unsigned.
  - div: lo = signed quotient, truncated toward zero; hi = remainder, taking the sign of the dividend.
  - divu: unsigned quotient to lo, unsigned remainder to hi.
- Divide by zero (B==0): still runs DIV_CYCLES with busy high, but commits nothing; HI/LO keep their old values.
- mthi/mtlo:
  - Single cycle, no busy: hi<=A (or lo<=A) on the accepting edge.
  - Ignored in RUN or when flush=1.
- md_out is purely combinational from the current hi/lo. It shows pre-commit values while busy.
- Counter width is 4 bits.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - md_op 7/8 use MULT_CYCLES: {hi,lo} <= {hi,lo} + product (signed for 7, unsigned for 8).
  - md_op 9/10 use MULT_CYCLES: {hi,lo} <= {hi,lo} - product.
  - The accumulator base is the {hi,lo} value at the accepting edge.
  - 64-bit arithmetic; wrap on overflow.
- Undefined: md_op 7-10 are treated as none (not accepted, busy stays 0, no state change).

Test Plan:
- Reset, then mult A=0xFFFFFFFD (-3), B=5 -> busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1; hi/lo unchanged (0) while busy.
- multu A=0xFFFFFFFF, B=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE. div A=0xFFFFFFF9 (-7), B=2 -> 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- mthi A=0x1234, then divu A=7, B=0 -> hi=0x1234 next cycle; divu busy 10 cycles, after which hi=0x1234 and lo are unchanged.
- mult with flush=1 on the start cycle -> busy stays 0, hi/lo unchanged. mult accepted, then flush=1 at busy cycle 2 -> still commits after cycle 5.
- div accepted, a second mult presented at busy cycle 3, rst_n pulsed low at busy cycle 6 -> the second command is ignored; busy=0 and hi=lo=0 immediately on reset; no later commit.
- MDU_MADD_EN defined: mtlo 5, mthi 0, then madd A=2, B=3 -> after 5 cycles hi=0, lo=0xB. msubu A=1, B=0xC -> hi=0xFFFFFFFF, lo=0xFFFFFFFF. With the macro undefined, md_op=7 leaves busy=0.
